// File: rtl/namuru_pkg.sv
// Shared constants for the namuru correlator timebase.
package namuru_pkg;

  localparam int DIV_W       = 24;
  localparam int CNT_W       = 24;
  localparam int RST_TIC_DIV = 1636799;
  localparam int RST_ACC_DIV = 16367;
  localparam int DIV_MIN     = 2;

endpackage

// File: rtl/namuru_divider.sv
// Clamped reload down-counter with a shadow divide register, producing a
// registered strobe when the count reads 0 and a pre-strobe one cycle earlier.
module namuru_divider
  import namuru_pkg::*;
#(
  parameter int W       = DIV_W,
  parameter int RST_VAL = RST_TIC_DIV
) (
  input  logic         gps_rec_clk,
  input  logic         sys_rst_n,
  input  logic         enable,
  input  logic         div_we,
  input  logic [W-1:0] div_dat,
  output logic         pre_strobe,
  output logic         strobe,
  output logic [W-1:0] divide
);

  localparam logic [W-1:0] MIN_VAL = W'(DIV_MIN);
  localparam logic [W-1:0] RST_DIV = W'(RST_VAL);
  localparam logic [W-1:0] RST_CNT = (RST_DIV < MIN_VAL) ? MIN_VAL : RST_DIV;

  logic [W-1:0] cnt;
  logic [W-1:0] eff_div;

  // Values below the minimum are kept in the readback but counted as the minimum.
  assign eff_div = (divide < MIN_VAL) ? MIN_VAL : divide;

  always_ff @(posedge gps_rec_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      divide     <= RST_DIV;
      cnt        <= RST_CNT;
      pre_strobe <= 1'b0;
      strobe     <= 1'b0;
    end else begin
      if (div_we) divide <= div_dat;
      if (!enable) begin
        cnt        <= eff_div;
        pre_strobe <= 1'b0;
        strobe     <= 1'b0;
      end else begin
        pre_strobe <= (cnt == W'(1));
        strobe     <= (cnt == '0);
        cnt        <= (cnt == '0) ? eff_div : cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/namuru_time_base.sv
// Timebase for the namuru GPS correlator: TIC/PRE_TIC/ACCUM strobes, TIC epoch
// counter and the sticky accumulation interrupt / overrun flags.
module namuru_time_base
  import namuru_pkg::*;
(
  input  logic             gps_rec_clk,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic             tic_div_we,
  input  logic             accum_div_we,
  input  logic [DIV_W-1:0] div_dat,
  input  logic             int_clr,
  output logic             pre_tic_enable,
  output logic             tic_enable,
  output logic             accum_enable,
  output logic             accum_int,
  output logic             accum_ovr,
  output logic [CNT_W-1:0] tic_count,
  output logic [DIV_W-1:0] tic_divide,
  output logic [DIV_W-1:0] accum_divide
);

  logic [CNT_W-1:0] tic_count_q;
  logic             acc_pre_unused;

  namuru_divider #(
    .W       (DIV_W),
    .RST_VAL (RST_TIC_DIV)
  ) u_tic_div (
    .gps_rec_clk (gps_rec_clk),
    .sys_rst_n   (sys_rst_n),
    .enable      (enable),
    .div_we      (tic_div_we),
    .div_dat     (div_dat),
    .pre_strobe  (pre_tic_enable),
    .strobe      (tic_enable),
    .divide      (tic_divide)
  );

  namuru_divider #(
    .W       (DIV_W),
    .RST_VAL (RST_ACC_DIV)
  ) u_acc_div (
    .gps_rec_clk (gps_rec_clk),
    .sys_rst_n   (sys_rst_n),
    .enable      (enable),
    .div_we      (accum_div_we),
    .div_dat     (div_dat),
    .pre_strobe  (acc_pre_unused),
    .strobe      (accum_enable),
    .divide      (accum_divide)
  );

  assign tic_count = tic_count_q;

  // A dump coincident with a clear wins; the clear then only suppresses a new overrun.
  always_ff @(posedge gps_rec_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tic_count_q <= '0;
      accum_int   <= 1'b0;
      accum_ovr   <= 1'b0;
    end else begin
      if (tic_enable) tic_count_q <= tic_count_q + 1'b1;
      if (accum_enable) begin
        accum_int <= 1'b1;
        if (accum_int && !int_clr) accum_ovr <= 1'b1;
      end else if (int_clr) begin
        accum_int <= 1'b0;
        accum_ovr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_namuru_time_base.sv
// Scoreboard bench for namuru_time_base: expected strobe cycles and sampled
// values are queued by the stimulus and consumed by a negedge monitor.
module tb_namuru_time_base;

  localparam int  DW      = 24;
  localparam int  CW      = 24;
  localparam longint RST_TIC = 1636799;
  localparam longint RST_ACC = 16367;

  localparam int K_CNT  = 0;
  localparam int K_INT  = 1;
  localparam int K_OVR  = 2;
  localparam int K_TDIV = 3;
  localparam int K_ADIV = 4;

  logic          gps_rec_clk;
  logic          sys_rst_n;
  logic          enable;
  logic          tic_div_we;
  logic          accum_div_we;
  logic [DW-1:0] div_dat;
  logic          int_clr;
  logic          pre_tic_enable;
  logic          tic_enable;
  logic          accum_enable;
  logic          accum_int;
  logic          accum_ovr;
  logic [CW-1:0] tic_count;
  logic [DW-1:0] tic_divide;
  logic [DW-1:0] accum_divide;

  namuru_time_base dut (
    .gps_rec_clk    (gps_rec_clk),
    .sys_rst_n      (sys_rst_n),
    .enable         (enable),
    .tic_div_we     (tic_div_we),
    .accum_div_we   (accum_div_we),
    .div_dat        (div_dat),
    .int_clr        (int_clr),
    .pre_tic_enable (pre_tic_enable),
    .tic_enable     (tic_enable),
    .accum_enable   (accum_enable),
    .accum_int      (accum_int),
    .accum_ovr      (accum_ovr),
    .tic_count      (tic_count),
    .tic_divide     (tic_divide),
    .accum_divide   (accum_divide)
  );

  typedef struct {
    int     cyc;
    int     kind;
    longint val;
  } smp_t;

  int   tic_q[$];
  int   pre_q[$];
  int   acc_q[$];
  smp_t smp_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  initial gps_rec_clk = 1'b0;
  always #5 gps_rec_clk = ~gps_rec_clk;

  always @(posedge gps_rec_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_tic(input int c);
    tic_q.push_back(c);
    pre_q.push_back(c - 1);
  endtask

  task automatic push_smp(input int c, input int k, input longint v);
    smp_t s;
    s.cyc  = c;
    s.kind = k;
    s.val  = v;
    smp_q.push_back(s);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge gps_rec_clk);
  endtask

  // Monitor: every strobe must match the head of its queue; overdue heads are misses.
  always @(negedge gps_rec_clk) begin
    smp_t s;
    if (tic_enable) begin
      if (tic_q.size() == 0) chk("tic_unexpected", cyc, -1);
      else                   chk("tic_time", cyc, tic_q.pop_front());
    end else if (tic_q.size() > 0 && tic_q[0] < cyc) begin
      chk("tic_missed", cyc, tic_q.pop_front());
    end
    if (pre_tic_enable) begin
      if (pre_q.size() == 0) chk("pre_unexpected", cyc, -1);
      else                   chk("pre_time", cyc, pre_q.pop_front());
    end else if (pre_q.size() > 0 && pre_q[0] < cyc) begin
      chk("pre_missed", cyc, pre_q.pop_front());
    end
    if (accum_enable) begin
      if (acc_q.size() == 0) chk("acc_unexpected", cyc, -1);
      else                   chk("acc_time", cyc, acc_q.pop_front());
    end else if (acc_q.size() > 0 && acc_q[0] < cyc) begin
      chk("acc_missed", cyc, acc_q.pop_front());
    end
    while (smp_q.size() > 0 && smp_q[0].cyc <= cyc) begin
      s = smp_q.pop_front();
      case (s.kind)
        K_CNT:   chk("tic_count", tic_count, s.val);
        K_INT:   chk("accum_int", accum_int, s.val);
        K_OVR:   chk("accum_ovr", accum_ovr, s.val);
        K_TDIV:  chk("tic_divide", tic_divide, s.val);
        default: chk("accum_divide", accum_divide, s.val);
      endcase
    end
  end

  initial begin
    int e1, e2, r, e3;
    sys_rst_n    = 1'b0;
    enable       = 1'b0;
    tic_div_we   = 1'b0;
    accum_div_we = 1'b0;
    div_dat      = '0;
    int_clr      = 1'b0;

    push_smp(2, K_CNT, 0);
    push_smp(2, K_INT, 0);
    push_smp(2, K_OVR, 0);
    push_smp(2, K_TDIV, RST_TIC);
    push_smp(2, K_ADIV, RST_ACC);

    wait_cyc(3);  sys_rst_n = 1'b1;
    wait_cyc(4);  tic_div_we = 1'b1; div_dat = 24'd9;
    wait_cyc(5);  tic_div_we = 1'b0; accum_div_we = 1'b1; div_dat = 24'd4;
    wait_cyc(6);  accum_div_we = 1'b0;

    // Phase 1: tic 9 / accum 4, mid-period tic rewrite to 3, interrupt flags.
    e1 = 10;
    wait_cyc(e1);
    push_tic(e1 + 10); push_tic(e1 + 20); push_tic(e1 + 30);
    push_tic(e1 + 40); push_tic(e1 + 44); push_tic(e1 + 48);
    for (int k = 1; k <= 9; k++) acc_q.push_back(e1 + 5 * k);
    push_smp(e1,      K_TDIV, 9);
    push_smp(e1,      K_ADIV, 4);
    push_smp(e1 + 6,  K_INT, 1);
    push_smp(e1 + 6,  K_OVR, 0);
    push_smp(e1 + 11, K_INT, 1);
    push_smp(e1 + 11, K_OVR, 1);
    push_smp(e1 + 13, K_INT, 0);
    push_smp(e1 + 13, K_OVR, 0);
    push_smp(e1 + 16, K_INT, 1);
    push_smp(e1 + 16, K_OVR, 0);
    push_smp(e1 + 21, K_CNT, 2);
    push_smp(e1 + 34, K_TDIV, 3);
    enable = 1'b1;
    wait_cyc(e1 + 12); int_clr = 1'b1;
    wait_cyc(e1 + 13); int_clr = 1'b0;
    wait_cyc(e1 + 15); int_clr = 1'b1;
    wait_cyc(e1 + 16); int_clr = 1'b0;
    wait_cyc(e1 + 33); tic_div_we = 1'b1; div_dat = 24'd3;
    wait_cyc(e1 + 34); tic_div_we = 1'b0;
    wait_cyc(e1 + 49); enable = 1'b0;
    wait_cyc(e1 + 50); accum_div_we = 1'b1; div_dat = 24'd0;
    wait_cyc(e1 + 51); accum_div_we = 1'b0; tic_div_we = 1'b1; div_dat = 24'd9;
    wait_cyc(e1 + 52); tic_div_we = 1'b0;

    // Phase 2: accum divide 0 behaves as 2; enable low for 7 cycles mid-period.
    e2 = e1 + 55;
    r  = e2 + 20;
    wait_cyc(e2);
    push_tic(e2 + 10); push_tic(r + 10); push_tic(r + 20);
    for (int k = 1; k <= 4; k++) acc_q.push_back(e2 + 3 * k);
    for (int k = 1; k <= 7; k++) acc_q.push_back(r + 3 * k);
    push_smp(e2,     K_CNT, 6);
    push_smp(e2,     K_TDIV, 9);
    push_smp(e2,     K_ADIV, 0);
    push_smp(r + 21, K_CNT, 9);
    enable = 1'b1;
    wait_cyc(e2 + 13); enable = 1'b0;
    wait_cyc(r);       enable = 1'b1;
    wait_cyc(r + 21);  enable = 1'b0;

    // Phase 3: tic_count wrap, then asynchronous reset mid-period.
    wait_cyc(r + 22);
    force dut.tic_count_q = 24'hFFFFFF;
    #1;
    release dut.tic_count_q;
    e3 = r + 25;
    wait_cyc(e3);
    push_tic(e3 + 10); push_tic(e3 + 20);
    for (int k = 1; k <= 7; k++) acc_q.push_back(e3 + 3 * k);
    push_smp(e3,      K_CNT, 24'hFFFFFF);
    push_smp(e3 + 11, K_CNT, 0);
    push_smp(e3 + 21, K_CNT, 1);
    enable = 1'b1;
    wait_cyc(e3 + 21);
    #1;
    sys_rst_n = 1'b0;
    enable    = 1'b0;
    #1;
    chk("rst_tic_enable",   tic_enable,     0);
    chk("rst_pre_tic",      pre_tic_enable, 0);
    chk("rst_accum_enable", accum_enable,   0);
    chk("rst_accum_int",    accum_int,      0);
    chk("rst_accum_ovr",    accum_ovr,      0);
    chk("rst_tic_count",    tic_count,      0);
    chk("rst_tic_divide",   tic_divide,     RST_TIC);
    chk("rst_accum_divide", accum_divide,   RST_ACC);
    wait_cyc(e3 + 24); sys_rst_n = 1'b1;
    push_smp(e3 + 26, K_CNT, 0);
    push_smp(e3 + 26, K_TDIV, RST_TIC);
    push_smp(e3 + 26, K_ADIV, RST_ACC);

    wait_cyc(e3 + 30);
    chk("tic_q_left", tic_q.size(), 0);
    chk("pre_q_left", pre_q.size(), 0);
    chk("acc_q_left", acc_q.size(), 0);
    chk("smp_q_left", smp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
